// File: rtl/encoder83_stream.sv
// encoder83_stream: 8-to-3 priority encoder feeding a 2-entry in-order output buffer.
// Define ENC_ONEHOT_CHECK_EN to enable multi-hot detection and the saturating err_cnt.
module encoder83_stream (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_vld,
  output logic       in_rdy,
  input  logic [7:0] in_data,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic [2:0] out_code,
  output logic       out_gs,
  output logic       out_err,
  output logic [7:0] err_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t     r_state, w_next;
  logic [4:0] r_mem [2];
  logic       r_wp, r_rp;
  logic       w_push, w_pop, w_gs, w_err;
  logic [2:0] w_code;
  logic [4:0] w_word;
  assign w_code = in_data[7] ? 3'd7 : in_data[6] ? 3'd6 : in_data[5] ? 3'd5 :
                  in_data[4] ? 3'd4 : in_data[3] ? 3'd3 : in_data[2] ? 3'd2 :
                  in_data[1] ? 3'd1 : 3'd0;
  assign w_gs   = |in_data;
  assign w_word = {w_err, w_gs, w_code};
  // Handshake depends only on registered occupancy, so no out_rdy -> in_rdy path.
  assign in_rdy  = r_state != FULL;
  assign out_vld = r_state != EMPTY;
  assign w_push  = in_vld && in_rdy;
  assign w_pop   = out_rdy && out_vld;
  assign {out_err, out_gs, out_code} = r_mem[r_rp];
`ifdef ENC_ONEHOT_CHECK_EN
  logic [7:0] r_err_cnt;
  assign w_err   = (in_data & (in_data - 8'd1)) != 8'd0;
  assign err_cnt = r_err_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err_cnt <= '0;
    else if (w_push && w_err && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
`else
  assign w_err   = 1'b0;
  assign err_cnt = 8'd0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= EMPTY;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_push && !w_pop) w_next = (r_state == EMPTY) ? ONE : FULL;
    else if (w_pop && !w_push) w_next = (r_state == FULL) ? ONE : EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_word;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
    end
endmodule
